// File: rtl/mul_pipe.sv
// mul_pipe: pipelined radix-4 Booth / Wallace-tree integer multiplier for the EX stage.
// Handles MUL / MULH / MULHU with a valid/ready handshake, a tag carried with each op,
// and flush. Everything in flight advances in lockstep and holds as a whole on an output stall.
module mul_pipe #(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             mul_clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mul_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW    = 2 * WIDTH;      // full product width
    localparam int NPP   = WIDTH / 2 + 1;  // Booth rows for a (WIDTH+2)-bit multiplier
    localparam int NROWS = NPP + 1;        // plus one row collecting the two's-complement +1 bits

    typedef logic [PW-1:0]             rowT;
    typedef logic [NROWS-1:0][PW-1:0]  rowsT;
    typedef logic [1:0][PW-1:0]        pairT;

    // Radix-4 Booth recoding. Operands are extended by two bits (sign for MUL/MULH, zero for
    // MULHU) so the multiplier has an even bit count. Negative digits are stored as the
    // one's complement, with the missing +1 collected in the last row.
    function automatic rowsT boothRows(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
        logic             signExt;
        logic [WIDTH+1:0] xe;
        logic [WIDTH+2:0] yx;
        logic [2:0]       grp;
        logic [WIDTH+2:0] mag;
        logic [WIDTH+2:0] term;
        logic             neg;
        rowT              ext;
        rowsT             rows;
        signExt = (op != 2'b10);
        xe      = {{2{signExt & a[WIDTH-1]}}, a};
        // Implicit zero below bit 0 so group i is simply yx[2i+2:2i]
        yx      = {{2{signExt & b[WIDTH-1]}}, b, 1'b0};
        rows    = '0;
        for (int i = 0; i < NPP; i++) begin
            grp = yx[2*i +: 3];
            neg = grp[2] & ~(grp[1] & grp[0]);
            case (grp)
                3'b001, 3'b010, 3'b101, 3'b110: mag = {xe[WIDTH+1], xe};
                3'b011, 3'b100:                 mag = {xe, 1'b0};
                default:                        mag = '0;
            endcase
            term             = neg ? ~mag : mag;
            ext              = {{(PW-WIDTH-3){term[WIDTH+2]}}, term};
            rows[i]          = ext << (2 * i);
            rows[NPP][2*i]   = neg;
        end
        return rows;
    endfunction

    // Wallace reduction: each level packs every full group of three rows into a sum and a
    // shifted carry row and passes the leftovers through, until two rows remain.
    function automatic pairT wallace(input rowsT rows);
        rowT cur [NROWS];
        rowT nxt [NROWS];
        rowT a;
        rowT b;
        rowT c;
        int  n;
        int  m;
        int  groups;
        for (int k = 0; k < NROWS; k++) begin
            cur[k] = rows[k];
            nxt[k] = '0;
        end
        n = NROWS;
        for (int lvl = 0; lvl < NROWS; lvl++) begin
            if (n > 2) begin
                groups = n / 3;
                m      = 0;
                for (int k = 0; k < NROWS; k++) begin
                    nxt[k] = '0;
                end
                for (int g = 0; g < NROWS / 3; g++) begin
                    if (g < groups) begin
                        a          = cur[3*g];
                        b          = cur[3*g+1];
                        c          = cur[3*g+2];
                        nxt[m]     = a ^ b ^ c;
                        nxt[m+1]   = ((a & b) | (a & c) | (b & c)) << 1;
                        m          = m + 2;
                    end
                end
                for (int r = 0; r < NROWS; r++) begin
                    if (r >= 3 * groups && r < n) begin
                        nxt[m] = cur[r];
                        m      = m + 1;
                    end
                end
                cur = nxt;
                n   = m;
            end
        end
        return {cur[1], cur[0]};
    endfunction

    // Final carry-propagate add and half select; reserved op 11 falls through to MUL.
    function automatic logic [WIDTH-1:0] finalSel(input logic [1:0] op, input pairT sc);
        rowT prod;
        prod = sc[0] + sc[1];
        if (op == 2'b01 || op == 2'b10) begin
            return prod[PW-1:WIDTH];
        end
        return prod[WIDTH-1:0];
    endfunction

    logic             stall;
    logic             advance;
    logic             lastValid;
    logic [TAG_W-1:0] lastTag;
    logic [WIDTH-1:0] lastRes;
    logic             outValidReg;
    logic [WIDTH-1:0] resultReg;
    logic [TAG_W-1:0] outTagReg;

    assign stall    = outValidReg & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall;

    if (PIPE_STAGES == 1) begin : gOne
        assign lastValid = in_valid;
        assign lastTag   = in_tag;
        assign lastRes   = finalSel(mul_op, wallace(boothRows(mul_op, x, y)));
    end else if (PIPE_STAGES == 2) begin : gTwo
        logic             s1Valid;
        logic [1:0]       s1Op;
        logic [TAG_W-1:0] s1Tag;
        rowsT             s1Rows;

        // Booth partial-product register; flush also drops the op being presented
        always_ff @(posedge mul_clk) begin
            if (!reset || flush) begin
                s1Valid <= 1'b0;
            end else if (advance) begin
                s1Valid <= in_valid;
            end
            if (advance) begin
                s1Op   <= mul_op;
                s1Tag  <= in_tag;
                s1Rows <= boothRows(mul_op, x, y);
            end
        end

        assign lastValid = s1Valid;
        assign lastTag   = s1Tag;
        assign lastRes   = finalSel(s1Op, wallace(s1Rows));
    end else begin : gThree
        logic             s1Valid;
        logic [1:0]       s1Op;
        logic [TAG_W-1:0] s1Tag;
        rowsT             s1Rows;
        logic             s2Valid;
        logic [1:0]       s2Op;
        logic [TAG_W-1:0] s2Tag;
        pairT             s2Pair;

        // Booth rows, then compressed sum/carry pair, both stepping only when not stalled
        always_ff @(posedge mul_clk) begin
            if (!reset || flush) begin
                s1Valid <= 1'b0;
                s2Valid <= 1'b0;
            end else if (advance) begin
                s1Valid <= in_valid;
                s2Valid <= s1Valid;
            end
            if (advance) begin
                s1Op   <= mul_op;
                s1Tag  <= in_tag;
                s1Rows <= boothRows(mul_op, x, y);
                s2Op   <= s1Op;
                s2Tag  <= s1Tag;
                s2Pair <= wallace(s1Rows);
            end
        end

        assign lastValid = s2Valid;
        assign lastTag   = s2Tag;
        assign lastRes   = finalSel(s2Op, s2Pair);
    end

    // Output register: cleared by reset, valid dropped by flush, held while stalled
    always_ff @(posedge mul_clk) begin
        if (!reset) begin
            outValidReg <= 1'b0;
            resultReg   <= '0;
            outTagReg   <= '0;
        end else if (flush) begin
            outValidReg <= 1'b0;
        end else if (advance) begin
            outValidReg <= lastValid;
            if (lastValid) begin
                resultReg <= lastRes;
                outTagReg <= lastTag;
            end
        end
    end

    assign out_valid = outValidReg;
    assign result    = resultReg;
    assign out_tag   = outTagReg;

endmodule
